// File: rtl/csa_serial_nibble_sequencer_if.sv
// Operand request and result return channels of the nibble-serial adder front end.
// A transfer happens on the rising edge where valid && ready; the source holds its payload stable while valid is high.
interface csa_serial_nibble_sequencer_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/csa_serial_nibble_sequencer.sv
// Feeds two WIDTH-bit operands through one external 4-bit adder slice, LSB nibble first,
// carrying between passes and assembling the WIDTH-bit sum plus carry-out.
module csa_serial_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    csa_serial_nibble_sequencer_if.slave        bus,
    output logic [3:0]                          slice_a_o,
    output logic [3:0]                          slice_b_o,
    output logic                                slice_cin_o,
    input  logic [3:0]                          slice_sum_i,
    input  logic                                slice_carry_i,
    output logic                                busy_o,
    output logic [1:0]                          state_o
);
    localparam int NNIB = WIDTH / 4;
    localparam int IDXW = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NNIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [IDXW-1:0]  idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             cout_q;
    logic             out_valid_q;
    logic             run;

    assign run = (state_q == S_RUN);

    // Slice inputs come only from registers so the external slice closes no comb loop.
    assign slice_a_o   = run ? a_q[{idx_q, 2'b00} +: 4] : 4'h0;
    assign slice_b_o   = run ? b_q[{idx_q, 2'b00} +: 4] : 4'h0;
    assign slice_cin_o = run ? carry_q : 1'b0;

    always_comb begin
        sum_d = sum_q;
        sum_d[{idx_q, 2'b00} +: 4] = slice_sum_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= slice_carry_i;
                    if (idx_q == IDX_LAST) begin
                        cout_q      <= slice_carry_i;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    // Result stays put until taken; a new add waits for the next cycle.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign busy_o        = (state_q != S_IDLE);
    assign state_o       = state_q;
endmodule

// File: tb/tb_csa_serial_nibble_sequencer.sv
// Bench for the nibble-serial adder front end with a real 4-bit carry-skip slice in the loop.
module tb_csa_serial_nibble_sequencer;
    localparam int WIDTH = 16;
    localparam int NNIB  = WIDTH / 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csa_serial_nibble_sequencer_if #(.WIDTH(WIDTH)) bus ();

    logic [3:0] slice_a, slice_b, slice_sum;
    logic       slice_cin, slice_carry, busy;
    logic [1:0] state;
    logic [4:0] sl_r;

    csa_serial_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .slice_a_o     (slice_a),
        .slice_b_o     (slice_b),
        .slice_cin_o   (slice_cin),
        .slice_sum_i   (slice_sum),
        .slice_carry_i (slice_carry),
        .busy_o        (busy),
        .state_o       (state)
    );

    // 4-bit carry-skip slice: carry bypasses the ripple when all bits propagate.
    always_comb begin
        sl_r        = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_cin};
        slice_sum   = sl_r[3:0];
        slice_carry = (&(slice_a ^ slice_b)) ? slice_cin : sl_r[4];
    end

    // ---------------- scoreboard ----------------
    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: one add in flight, result = a+b+cin, due NNIB edges after accept.
    logic [WIDTH:0]   exp_q[$];
    bit               m_busy = 1'b0;
    int               m_acc_n, m_ready_n;
    logic [WIDTH-1:0] m_a, m_b;
    logic             m_cin;
    logic [WIDTH:0]   m_last = '0;
    int               neg_n = 0;
    int               acc_cnt = 0;
    int               stall_cnt = 0;
    int               prev_acc_n = 0;
    bit               have_prev = 1'b0;
    bit               gap_en = 1'b0;

    always @(negedge clk) begin : compare
        bit             exp_ov;
        int             k;
        logic [WIDTH:0] mask, lo;
        neg_n++;
        if (!gap_en) have_prev = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            m_last = '0;
            exp_q.delete();
        end else begin
            exp_ov = m_busy && (neg_n >= m_ready_n);
            chk("in_ready", bus.in_ready, !m_busy);
            chk("busy", busy, m_busy);
            chk("out_valid", bus.out_valid, exp_ov);
            if (exp_ov) begin
                chk("sum", bus.sum, exp_q[0][WIDTH-1:0]);
                chk("cout", bus.cout, exp_q[0][WIDTH]);
            end else if (!m_busy) begin
                chk("idle_sum_held", bus.sum, m_last[WIDTH-1:0]);
                chk("idle_cout_held", bus.cout, m_last[WIDTH]);
                chk("idle_slice", {slice_a, slice_b, slice_cin}, 0);
            end else begin
                k    = neg_n - m_acc_n - 1;
                mask = ({{WIDTH{1'b0}}, 1'b1} << (4 * k)) - 1'b1;
                lo   = ({1'b0, m_a} & mask) + ({1'b0, m_b} & mask) + {{WIDTH{1'b0}}, m_cin};
                chk("slice_a", slice_a, m_a[4*k +: 4]);
                chk("slice_b", slice_b, m_b[4*k +: 4]);
                chk("slice_cin", slice_cin, lo[4*k]);
            end
            if (exp_ov && bus.out_ready) begin
                m_busy = 1'b0;
                m_last = exp_q.pop_front();
            end else if (exp_ov) begin
                stall_cnt++;
            end else if (!m_busy && bus.in_valid) begin
                if (gap_en && have_prev) chk("accept_gap", neg_n - prev_acc_n, NNIB + 2 + stall_cnt);
                have_prev  = 1'b1;
                prev_acc_n = neg_n;
                stall_cnt  = 0;
                m_busy     = 1'b1;
                m_acc_n    = neg_n;
                m_ready_n  = neg_n + NNIB + 1;
                m_a        = bus.a;
                m_b        = bus.b;
                m_cin      = bus.cin;
                exp_q.push_back({1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin});
                acc_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_accept(input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk({nm, "_accept_timeout"}, 0, 1);
    endtask

    task automatic wait_out_valid(input string nm, output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) chk({nm, "_result_timeout"}, 0, 1);
    endtask

    task automatic run_add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc,
                           input logic [WIDTH-1:0] es, input logic ec, input string nm);
        int lat;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.a         = ta;
        bus.b         = tb_v;
        bus.cin       = tc;
        bus.out_ready = 1'b1;
        wait_accept(nm);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_out_valid(nm, lat);
        // lat counts negedges after the accept edge; out_valid shows after NNIB further edges
        chk({nm, "_latency"}, lat, NNIB + 1);
        chk({nm, "_sum"}, bus.sum, es);
        chk({nm, "_cout"}, bus.cout, ec);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int lat;
        int target;
        bit done;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_busy", busy, 0);

        run_add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "t1");
        run_add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "t2");
        run_add(16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 1'b1, "t3");

        // Backpressure in DONE with in_valid held high.
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.a         = 16'hABCD;
        bus.b         = 16'h1234;
        bus.cin       = 1'b1;
        bus.out_ready = 1'b0;
        wait_accept("t4");
        wait_out_valid("t4", lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_out_valid", bus.out_valid, 1);
            chk("t4_sum", bus.sum, 16'hBE02);
            chk("t4_cout", bus.cout, 0);
            chk("t4_in_ready", bus.in_ready, 0);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_after_in_ready", bus.in_ready, 1);
        chk("t4_after_sum_held", bus.sum, 16'hBE02);

        // Reset during the second RUN cycle.
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.a        = 16'h1111;
        bus.b        = 16'h2222;
        bus.cin      = 1'b0;
        wait_accept("t5");
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t5_out_valid", bus.out_valid, 0);
        chk("t5_sum", bus.sum, 0);
        chk("t5_slice_a", slice_a, 0);
        chk("t5_slice_b", slice_b, 0);
        chk("t5_slice_cin", slice_cin, 0);
        chk("t5_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_add(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, "t5b");

        // Back-to-back random adds, in_valid always high, random out_ready.
        gap_en       = 1'b1;
        target       = acc_cnt + 1000;
        bus.in_valid = 1'b1;
        done         = 1'b0;
        for (int c = 0; c < 40000; c++) begin
            @(posedge clk); #1;
            bus.a         = WIDTH'($urandom_range(0, 65535));
            bus.b         = WIDTH'($urandom_range(0, 65535));
            bus.cin       = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (acc_cnt >= target) begin
                done = 1'b1;
                break;
            end
        end
        chk("random_progress", done, 1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (!m_busy) begin
                done = 1'b1;
                break;
            end
        end
        chk("random_drain", done, 1);
        gap_en = 1'b0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", pass_cnt, chk_cnt);
        $fatal(1, "timeout");
    end
endmodule
